// File: rtl/draw_sequencer_if.sv
// Drawer-facing and adapter-facing signal bundle of the draw sequencer.
// master = sequencer side, slave = drawers plus VGA adapter side.
interface draw_sequencer_if #(
  parameter int unsigned N_SRC = 4
);
  logic [N_SRC-1:0]   src_done;
  logic [N_SRC-1:0]   src_valid;
  logic [8*N_SRC-1:0] src_x;
  logic [7*N_SRC-1:0] src_y;
  logic [3*N_SRC-1:0] src_c;
  logic [N_SRC-1:0]   src_resetn;
  logic [N_SRC-1:0]   src_en;
  logic [7:0]         vga_x;
  logic [6:0]         vga_y;
  logic [2:0]         vga_colour;
  logic               vga_plot;

  modport master (
    input  src_done, src_valid, src_x, src_y, src_c,
    output src_resetn, src_en, vga_x, vga_y, vga_colour, vga_plot
  );

  modport slave (
    output src_done, src_valid, src_x, src_y, src_c,
    input  src_resetn, src_en, vga_x, vga_y, vga_colour, vga_plot
  );
endinterface

// File: rtl/draw_sequencer.sv
// Per-frame drawer scheduler: arms requested drawers one at a time in priority
// order (index 0 first) and forwards only the active drawer's pixels to the VGA adapter.
module draw_sequencer #(
  parameter int unsigned N_SRC   = 4,
  parameter logic [15:0] TIMEOUT = 16'd20000
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             frame_tick_i,
  input  logic [N_SRC-1:0] req_mask_i,
  draw_sequencer_if.master bus,
  output logic             busy_o,
  output logic             frame_done_o,
  output logic             overrun_o,
  output logic             timeout_err_o
);
  localparam int unsigned IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_RUN  = 3'd2,
    S_NEXT = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e           state_q;
  logic [N_SRC-1:0] pend_q;
  logic [IDX_W-1:0] cur_q;
  logic [CNT_W-1:0] wdog_q;
  logic [N_SRC-1:0] src_resetn_q;
  logic [N_SRC-1:0] src_en_q;
  logic [7:0]       vga_x_q;
  logic [6:0]       vga_y_q;
  logic [2:0]       vga_colour_q;
  logic             vga_plot_q;
  logic             busy_q;
  logic             frame_done_q;
  logic             overrun_q;
  logic             timeout_err_q;

  // Per-source views of the packed pixel buses.
  logic [7:0] sx [N_SRC];
  logic [6:0] sy [N_SRC];
  logic [2:0] sc [N_SRC];

  for (genvar g = 0; g < N_SRC; g++) begin : g_unpack
    assign sx[g] = bus.src_x[8*g +: 8];
    assign sy[g] = bus.src_y[7*g +: 7];
    assign sc[g] = bus.src_c[3*g +: 3];
  end

  function automatic logic [IDX_W-1:0] lowest_set(input logic [N_SRC-1:0] m);
    lowest_set = '0;
    for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
      if (m[i]) lowest_set = IDX_W'(i);
    end
  endfunction

  logic [N_SRC-1:0] cur_oh_d;
  logic [N_SRC-1:0] pend_clr_d;
  logic [IDX_W-1:0] first_idx_d;
  logic [IDX_W-1:0] next_idx_d;
  logic             cur_done_d;
  logic             cur_valid_d;
  logic             wdog_hit_d;

  always_comb begin
    cur_oh_d    = N_SRC'(1) << cur_q;
    pend_clr_d  = pend_q & ~cur_oh_d;
    first_idx_d = lowest_set(req_mask_i);
    next_idx_d  = lowest_set(pend_clr_d);
    cur_done_d  = bus.src_done[cur_q];
    cur_valid_d = bus.src_valid[cur_q];
    wdog_hit_d  = (wdog_q == TIMEOUT - 16'd1);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      pend_q        <= '0;
      cur_q         <= '0;
      wdog_q        <= '0;
      src_resetn_q  <= '1;
      src_en_q      <= '0;
      vga_x_q       <= '0;
      vga_y_q       <= '0;
      vga_colour_q  <= '0;
      vga_plot_q    <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      src_resetn_q <= '1;
      frame_done_q <= 1'b0;
      vga_plot_q   <= 1'b0;
      if (frame_tick_i && (state_q != S_IDLE)) overrun_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if (frame_tick_i) begin
            pend_q <= req_mask_i;
            busy_q <= 1'b1;
            if (req_mask_i != '0) begin
              cur_q        <= first_idx_d;
              src_resetn_q <= ~(N_SRC'(1) << first_idx_d);
              state_q      <= S_ARM;
            end else begin
              frame_done_q <= 1'b1;
              state_q      <= S_DONE;
            end
          end
        end
        S_ARM: begin
          src_en_q <= cur_oh_d;
          wdog_q   <= '0;
          state_q  <= S_RUN;
        end
        S_RUN: begin
          // Done gates the plot so the finishing cycle never writes a pixel.
          vga_x_q      <= sx[cur_q];
          vga_y_q      <= sy[cur_q];
          vga_colour_q <= sc[cur_q];
          vga_plot_q   <= cur_valid_d & ~cur_done_d;
          wdog_q       <= wdog_q + 16'd1;
          if (cur_done_d || wdog_hit_d) begin
            src_en_q <= '0;
            state_q  <= S_NEXT;
            if (!cur_done_d) timeout_err_q <= 1'b1;
          end
        end
        S_NEXT: begin
          pend_q <= pend_clr_d;
          if (pend_clr_d != '0) begin
            cur_q        <= next_idx_d;
            src_resetn_q <= ~(N_SRC'(1) << next_idx_d);
            state_q      <= S_ARM;
          end else begin
            frame_done_q <= 1'b1;
            state_q      <= S_DONE;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.src_resetn = src_resetn_q;
  assign bus.src_en     = src_en_q;
  assign bus.vga_x      = vga_x_q;
  assign bus.vga_y      = vga_y_q;
  assign bus.vga_colour = vga_colour_q;
  assign bus.vga_plot   = vga_plot_q;
  assign busy_o         = busy_q;
  assign frame_done_o   = frame_done_q;
  assign overrun_o      = overrun_q;
  assign timeout_err_o  = timeout_err_q;
endmodule

// File: tb/tb_draw_sequencer.sv
// Randomised bench for draw_sequencer: behavioural drawers feed a pixel
// scoreboard, and per-frame traces are checked against the scheduling rules.
module tb_draw_sequencer;
  localparam int NS = 4;
  localparam int TO = 16;
  localparam int D  = 512;

  logic       clk;
  logic       resetn;
  logic       frame_tick;
  logic [3:0] req_mask;
  logic       busy_o, frame_done_o, overrun_o, timeout_err_o;

  draw_sequencer_if #(.N_SRC(NS)) bus ();

  draw_sequencer #(.N_SRC(NS), .TIMEOUT(16'(TO))) dut (
    .clk          (clk),
    .resetn       (resetn),
    .frame_tick_i (frame_tick),
    .req_mask_i   (req_mask),
    .bus          (bus),
    .busy_o       (busy_o),
    .frame_done_o (frame_done_o),
    .overrun_o    (overrun_o),
    .timeout_err_o(timeout_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [17:0] exp_q [$];

  // Drawer behaviour: 0 = emit npix pixels then done, 1 = never done, 2 = done on watchdog's last cycle
  int mode     [NS];
  int npix     [NS];
  int emitted  [NS];
  int run_cnt  [NS];
  int done_idx [NS];
  logic [3:0] done_v;
  bit exp_terr, exp_ovr;
  int last_plots;

  logic [3:0] en_tr   [D];
  logic [3:0] rstn_tr [D];
  logic       busy_tr [D];
  logic       fd_tr   [D];
  logic       plot_tr [D];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_src(input int i, input int m, input int np);
    mode[i] = m;
    npix[i] = np;
  endtask

  function automatic int exp_len(input int s);
    if (mode[s] != 0) return TO;
    return done_idx[s] + 1;
  endfunction

  // Drawers: react to src_resetn/src_en and push every forwardable pixel.
  initial begin
    logic       v;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    bus.src_done = '0; bus.src_valid = '0;
    bus.src_x = '0; bus.src_y = '0; bus.src_c = '0;
    done_v = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NS; i++) begin
        x = 8'($urandom); y = 7'($urandom); c = 3'($urandom); v = 1'($urandom);
        if (bus.src_resetn[i] === 1'b0) begin
          emitted[i] = 0; run_cnt[i] = 0; done_v[i] = 1'b0;
        end else if (bus.src_en[i] === 1'b1) begin
          if (!done_v[i]) begin
            if (mode[i] == 0 && emitted[i] == npix[i]) begin
              done_v[i] = 1'b1; done_idx[i] = run_cnt[i];
            end else if (mode[i] == 2 && run_cnt[i] == TO - 1) begin
              done_v[i] = 1'b1; done_idx[i] = run_cnt[i];
            end else begin
              if (mode[i] == 0 && run_cnt[i] >= 8) v = 1'b1;
              if (v) begin
                emitted[i]++;
                exp_q.push_back({x, y, c});
              end
            end
          end
          run_cnt[i]++;
        end
        bus.src_valid[i]       = v;
        bus.src_done[i]        = done_v[i];
        bus.src_x[8*i +: 8]    = x;
        bus.src_y[7*i +: 7]    = y;
        bus.src_c[3*i +: 3]    = c;
      end
    end
  end

  // Monitor: trace every cycle, enforce one-hot enable, score forwarded pixels.
  initial begin
    int idx;
    logic [17:0] p;
    forever begin
      @(posedge clk); #1;
      cyc++;
      idx = cyc % D;
      en_tr[idx]   = bus.src_en;
      rstn_tr[idx] = bus.src_resetn;
      busy_tr[idx] = busy_o;
      fd_tr[idx]   = frame_done_o;
      plot_tr[idx] = bus.vga_plot;
      chk("en_onehot", 32'($countones(bus.src_en) <= 1), 32'd1);
      if (bus.vga_plot === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL plot_unexpected: got plot x=%0h y=%0h c=%0h, expected no plot (cycle %0d)",
                   bus.vga_x, bus.vga_y, bus.vga_colour, cyc);
        end else begin
          p = exp_q.pop_front();
          chk("pixel", 32'({bus.vga_x, bus.vga_y, bus.vga_colour}), 32'(p));
        end
      end
    end
  end

  task automatic run_frame(input logic [3:0] mask, input int ovr_at);
    int t, tend, nfd, lo;
    bit got, ok;
    int e_src [$];
    int s_src [$];
    int s_start [$];
    int s_end [$];
    logic [3:0] prev, en;
    for (int i = 0; i < NS; i++) begin
      if (mask[i]) begin
        e_src.push_back(i);
        if (mode[i] == 1) exp_terr = 1'b1;
      end
    end
    @(negedge clk);
    t = cyc; frame_tick = 1'b1; req_mask = mask;
    got = 1'b0; tend = t;
    for (int step = 1; step <= 300; step++) begin
      @(negedge clk);
      frame_tick = (step == ovr_at);
      if (step == ovr_at) exp_ovr = 1'b1;
      req_mask = 4'($urandom);
      if (frame_done_o) begin got = 1'b1; tend = cyc; break; end
    end
    frame_tick = 1'b0;
    chk("frame_done_seen", 32'(got), 32'd1);
    if (!got) return;

    ok = 1'b1; nfd = 0; last_plots = 0;
    for (int cy = t + 1; cy <= tend; cy++) begin
      if (busy_tr[cy % D] !== 1'b1) ok = 1'b0;
      if (fd_tr[cy % D] === 1'b1) nfd++;
      if (plot_tr[cy % D] === 1'b1) last_plots++;
    end
    chk("busy_in_frame", 32'(ok), 32'd1);
    chk("frame_done_once", 32'(nfd), 32'd1);

    prev = '0;
    for (int cy = t; cy <= tend; cy++) begin
      en = en_tr[cy % D];
      if (prev != '0 && en != prev) s_end.push_back(cy - 1);
      if (en != '0 && en != prev) begin
        lo = 0;
        for (int b = NS - 1; b >= 0; b--) if (en[b]) lo = b;
        s_src.push_back(lo);
        s_start.push_back(cy);
      end
      prev = en;
    end
    if (prev != '0) s_end.push_back(tend);

    chk("seg_count", 32'(s_src.size()), 32'(e_src.size()));
    if (mask == '0) begin
      chk("empty_done_latency", 32'(tend - t), 32'd1);
    end else if (s_src.size() == e_src.size()) begin
      for (int k = 0; k < e_src.size(); k++) begin
        chk("seg_src", 32'(s_src[k]), 32'(e_src[k]));
        chk("arm_rstn", 32'(rstn_tr[(s_start[k] - 1) % D]), 32'(4'(~(4'b0001 << e_src[k]))));
        chk("seg_len", 32'(s_end[k] - s_start[k] + 1), 32'(exp_len(e_src[k])));
        if (k == 0) chk("first_en_latency", 32'(s_start[k] - t), 32'd2);
        else        chk("inter_src_gap", 32'(s_start[k] - s_end[k-1] - 1), 32'd2);
      end
      chk("done_after_last", 32'(tend - s_end[s_end.size() - 1]), 32'd2);
    end
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    chk("timeout_err", 32'(timeout_err_o), 32'(exp_terr));
    chk("overrun", 32'(overrun_o), 32'(exp_ovr));
    @(negedge clk);
    chk("busy_after_done", 32'(busy_o), 32'd0);
    if (ovr_at > 0) begin
      repeat (3) @(negedge clk);
      chk("no_second_frame", 32'({busy_o, bus.src_en}), 32'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    bit got;
    logic [3:0] m;
    for (int i = 0; i < NS; i++) begin
      mode[i] = 0; npix[i] = 1; emitted[i] = 0; run_cnt[i] = 0; done_idx[i] = 0;
    end
    exp_terr = 1'b0; exp_ovr = 1'b0;
    resetn = 1'b0; frame_tick = 1'b0; req_mask = '0;
    repeat (3) @(negedge clk);
    chk("rst_src_resetn", 32'(bus.src_resetn), 32'hF);
    chk("rst_src_en", 32'(bus.src_en), 32'd0);
    chk("rst_flags", 32'({busy_o, frame_done_o, overrun_o, timeout_err_o}), 32'd0);
    chk("rst_vga", 32'({bus.vga_x, bus.vga_y, bus.vga_colour, bus.vga_plot}), 32'd0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // Single source, three pixels
    set_src(0, 0, 3);
    run_frame(4'b0001, 0);
    chk("single_plot_count", 32'(last_plots), 32'd3);

    // Priority order
    set_src(1, 0, 2); set_src(3, 0, 3);
    run_frame(4'b1010, 0);

    // Done on the watchdog's final cycle is a normal finish
    set_src(0, 2, 1);
    run_frame(4'b0001, 0);

    // Empty mask
    run_frame(4'b0000, 0);
    chk("empty_no_plot", 32'(last_plots), 32'd0);

    // Watchdog abort, then sequencing continues
    set_src(2, 1, 1); set_src(3, 0, 2);
    run_frame(4'b1100, 0);

    // Overrun while busy
    set_src(0, 0, 2); set_src(1, 0, 3);
    run_frame(4'b0011, 3);

    // Reset during source 1's RUN
    set_src(1, 0, 4); set_src(2, 0, 2);
    @(negedge clk); frame_tick = 1'b1; req_mask = 4'b0110;
    @(negedge clk); frame_tick = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.src_en[1] === 1'b1 && run_cnt[1] >= 2) begin got = 1'b1; break; end
    end
    chk("reached_run_src1", 32'(got), 32'd1);
    resetn = 1'b0;
    @(negedge clk);
    chk("midrst_busy_en_plot", 32'({busy_o, bus.src_en, bus.vga_plot}), 32'd0);
    chk("midrst_src_resetn", 32'(bus.src_resetn), 32'hF);
    chk("midrst_sticky", 32'({overrun_o, timeout_err_o}), 32'd0);
    resetn = 1'b1;
    exp_q.delete();
    exp_terr = 1'b0; exp_ovr = 1'b0;
    @(negedge clk);
    run_frame(4'b0110, 0);

    // Randomised frames
    for (int f = 0; f < 12; f++) begin
      m = 4'($urandom);
      for (int i = 0; i < NS; i++) begin
        int r;
        r = int'($urandom_range(0, 7));
        set_src(i, (r == 0) ? 1 : (r == 1) ? 2 : 0, int'($urandom_range(1, 4)));
      end
      run_frame(m, (m != '0 && $urandom_range(0, 2) == 0) ? 3 : 0);
      repeat (int'($urandom_range(0, 3))) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/draw_sequencer.md
# draw_sequencer

Per-frame draw scheduler that sits directly downstream of the screen/sprite drawer blocks and directly upstream of the VGA adapter. On each frame tick it runs the requested drawers one at a time in fixed priority order, re-arms each one, waits for its done flag, and forwards only the active drawer's pixel stream to the adapter. It is the single owner of the adapter's x/y/colour/plot inputs.

## Interface
- N_SRC, 4: number of drawer sources. Index 0 has the highest priority.
- TIMEOUT, 16'd20000: maximum number of RUN cycles allowed for one source before it is aborted. 160×120×3 = 57600, so full-screen drawers need TIMEOUT ≥ 16'd60000.
- clk  in  1  system clock
- resetn  in  1  synchronous, active-low reset
- frame_tick  in  1  one-cycle pulse that starts a frame
- req_mask  in  N_SRC  sources to draw this frame; sampled only on an accepted frame_tick
- src_done  in  N_SRC  per-source done flag; level, sticky until that source is re-armed
- src_valid  in  N_SRC  per-source pixel-valid qualifier
- src_x  in  8*N_SRC  packed x; source i occupies [8i+7:8i]
- src_y  in  7*N_SRC  packed y; source i occupies [7i+6:7i]
- src_c  in  3*N_SRC  packed colour; source i occupies [3i+2:3i]
- src_resetn  out  N_SRC  per-source re-arm; active-low, one cycle
- src_en  out  N_SRC  one-hot (or zero) drawer enable
- vga_x  out  8  registered x to the adapter
- vga_y  out  7  registered y to the adapter
- vga_colour  out  3  registered colour to the adapter
- vga_plot  out  1  registered write strobe
- busy  out  1  high whenever state ≠ IDLE
- frame_done  out  1  one-cycle pulse at the end of a frame
- overrun  out  1  sticky; a frame_tick arrived while busy
- timeout_err  out  1  sticky; a source was aborted by the watchdog

## Operation
- States: IDLE, ARM, RUN, NEXT, DONE.
- IDLE, on frame_tick:
  - latch req_mask into pend;
  - if pend ≠ 0, go to ARM with cur = lowest set bit of pend;
  - otherwise go to DONE.
- ARM: src_resetn[cur] = 0 for exactly this cycle, then go to RUN. All other src_resetn bits stay 1.
- RUN:
  - src_en[cur] = 1.
  - Each cycle, register {src_x, src_y, src_c}[cur] into vga_x/y/colour, and register vga_plot = src_valid[cur] & ~src_done[cur].
  - The watchdog counter starts at 0 on entry and increments once per RUN cycle.
  - Leave for NEXT when src_done[cur] = 1, or when the counter reaches TIMEOUT-1; a timeout also sets timeout_err.
  - If both conditions occur in the same cycle, treat it as a normal finish: timeout_err is not set.
- NEXT:
  - clear pend[cur] and hold src_en at 0;
  - if pend ≠ 0, go to ARM with cur = lowest remaining set bit;
  - otherwise go to DONE.
- DONE: frame_done = 1 for this cycle, then go to IDLE.
- A frame_tick outside IDLE is ignored and sets overrun. req_mask changes during a frame have no effect.
- Outside RUN: vga_plot = 0, and vga_x/y/colour hold their last values.
- overrun and timeout_err are cleared only by reset.
- Reset, including mid-frame:
  - state = IDLE, pend = 0, cur = 0, counter = 0;
  - all outputs 0, except src_resetn, which is all 1s;
  - a drawer that was mid-draw is left unfinished; it is re-armed the next time it is scheduled.

## Timing
- frame_tick accepted at cycle t:
  - ARM at t+1;
  - RUN begins at t+2, with src_en high from t+2;
  - the first registered vga output is visible at t+3.
- Pipeline latency from source to adapter is 1 cycle: src_* at cycle k appear on vga_* at k+1.
- src_done sampled high at cycle d:
  - src_en is 0 from d+1 (NEXT);
  - no plot is forwarded from cycle d's inputs, because of the ~src_done gating.
- Inter-source gap is 2 cycles (NEXT, ARM) with src_en = 0.
- Empty mask: frame_tick at t, DONE at t+1, frame_done high at t+1, busy low at t+2.
- frame_done coincides with the DONE state. busy is high from t+1 through DONE inclusive.

## Test plan
- Single source: req_mask = 4'b0001, drawer 0 emits 3 valid pixels, then done. Required: src_resetn[0] low at t+1; src_en[0] high at t+2; exactly 3 vga_plot cycles with matching x/y/c delayed 1 cycle; frame_done pulses once.
- Priority order: req_mask = 4'b1010. Required: source 1 fully completes before src_en[3] rises; 2-cycle src_en = 0 gap between them; src_en never has more than one bit set.
- Timeout: TIMEOUT = 16, source 2 never asserts done. Required: src_en[2] high for exactly 16 cycles; timeout_err = 1; sequencing continues to the next source and frame_done still pulses.
- Overrun: frame_tick pulses again while busy. Required: overrun = 1; the frame in progress is unaffected; no second frame starts.
- Empty mask and done/timeout tie: req_mask = 0 gives frame_done at t+1 with vga_plot never high. Done asserted on the watchdog's final cycle gives timeout_err = 0.
- Reset mid-RUN: resetn = 0 for 1 cycle during source 1's RUN. Required: the next cycle shows busy = 0, src_en = 0, vga_plot = 0, src_resetn = all 1s, and sticky flags = 0. The following frame_tick restarts cleanly from the lowest set bit of req_mask.
